// File: rtl/registros_rx.sv
// Receiver for the 13-slot serial byte frame: hunts sync, checks the marker,
// deserializes N_DATA bytes into a shadow bank and commits them atomically.
module registros_rx #(
  parameter int             N_DATA = 11,
  parameter int             W      = 8,
  parameter logic [W-1:0]   MARK   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [W-1:0]        data_in,
  input  logic                bit_inicio,
  output logic [N_DATA*W-1:0] datos_out,
  output logic                frame_valid,
  output logic                frame_error,
  output logic [7:0]          frame_cnt,
  output logic [1:0]          dbg_state
);

  localparam int SW = $clog2(N_DATA + 1);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_MARK = 2'd1,
    S_DATA = 2'd2,
    S_SYNC = 2'd3
  } state_t;

  state_t                state_q;
  logic [SW-1:0]         slot_q;
  logic [N_DATA*W-1:0]   shadow_q;
  logic [N_DATA*W-1:0]   datos_q;
  logic                  frame_valid_q;
  logic                  frame_error_q;
  logic [7:0]            frame_cnt_q;
  logic [1:0]            rst_sync_q;
  logic                  rst_n_int;

  // Assertion is immediate, release is aligned to clk through two flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q       <= S_HUNT;
      slot_q        <= '0;
      shadow_q      <= '0;
      datos_q       <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        S_HUNT: begin
          if (!bit_inicio) state_q <= S_MARK;
        end
        S_MARK: begin
          if (data_in == MARK) begin
            state_q <= S_DATA;
            slot_q  <= SW'(1);
          end else begin
            frame_error_q <= 1'b1;
            state_q       <= S_HUNT;
          end
        end
        S_DATA: begin
          // Early sync: drop the partial frame and treat this slot as a new sync.
          if (!bit_inicio) begin
            frame_error_q <= 1'b1;
            shadow_q      <= '0;
            slot_q        <= '0;
            state_q       <= S_MARK;
          end else begin
            for (int k = 0; k < N_DATA; k++) begin
              if (slot_q == SW'(k + 1)) shadow_q[k*W +: W] <= data_in;
            end
            if (slot_q >= SW'(N_DATA)) state_q <= S_SYNC;
            else                       slot_q  <= slot_q + SW'(1);
          end
        end
        S_SYNC: begin
          if (!bit_inicio) begin
            datos_q       <= shadow_q;
            frame_valid_q <= 1'b1;
            frame_cnt_q   <= frame_cnt_q + 8'd1;
            slot_q        <= '0;
            state_q       <= S_MARK;
          end else begin
            frame_error_q <= 1'b1;
            slot_q        <= '0;
            state_q       <= S_HUNT;
          end
        end
        default: state_q <= S_HUNT;
      endcase
    end
  end

  assign datos_out   = datos_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign frame_cnt   = frame_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_registros_rx.sv
// Directed bench for registros_rx: good frames, marker/sync violations,
// mid-frame reset and frame counter wrap, checked against a frame queue.
module tb_registros_rx;

  localparam int N_DATA = 11;
  localparam int W      = 8;
  localparam int BW     = N_DATA * W;

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  data_in;
  logic          bit_inicio;
  logic [BW-1:0] datos_out;
  logic          frame_valid;
  logic          frame_error;
  logic [7:0]    frame_cnt;
  logic [1:0]    dbg_state;

  int            n_cmp = 0;
  int            n_err = 0;
  int            n_fv  = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] exp_bank;
  logic [7:0]    exp_cnt;

  registros_rx dut (
    .clk         (clk),
    .reset       (reset),
    .data_in     (data_in),
    .bit_inicio  (bit_inicio),
    .datos_out   (datos_out),
    .frame_valid (frame_valid),
    .frame_error (frame_error),
    .frame_cnt   (frame_cnt),
    .dbg_state   (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] make_frame(input logic [7:0] base);
    logic [BW-1:0] v;
    v = '0;
    for (int k = 0; k < N_DATA; k++) v[k*W +: W] = base + 8'(k);
    return v;
  endfunction

  // driver tasks: one slot per clock, pulses checked right after the sampling edge
  task automatic slot(input logic bi, input logic [7:0] d, input logic exp_fv, input logic exp_fe);
    @(negedge clk);
    bit_inicio = bi;
    data_in    = d;
    @(posedge clk);
    #1;
    check("frame_valid", BW'(frame_valid), BW'(exp_fv));
    check("frame_error", BW'(frame_error), BW'(exp_fe));
    if (frame_valid) n_fv++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) slot(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  task automatic first_sync();
    slot(1'b0, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
  endtask

  // marker slot plus n data bytes base..base+n-1
  task automatic send_body(input logic [7:0] mark, input logic [7:0] base, input int n);
    slot(1'b1, mark, 1'b0, mark != 8'h00);
    if (mark == 8'h00)
      for (int k = 0; k < n; k++) slot(1'b1, base + 8'(k), 1'b0, 1'b0);
  endtask

  task automatic good_frame(input logic [7:0] base);
    send_body(8'h00, base, N_DATA);
    exp_q.push_back(make_frame(base));
  endtask

  task automatic commit_sync();
    slot(1'b0, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL commit_queue: got empty expected one frame");
    end else begin
      exp_bank = exp_q.pop_front();
    end
    exp_cnt = exp_cnt + 8'd1;
    check("datos_out", datos_out, exp_bank);
    check("frame_cnt", BW'(frame_cnt), BW'(exp_cnt));
  endtask

  task automatic check_bank(input string tag);
    check({tag, "_datos"}, datos_out, exp_bank);
    check({tag, "_cnt"}, BW'(frame_cnt), BW'(exp_cnt));
  endtask

  initial begin
    reset      = 1'b0;
    bit_inicio = 1'b1;
    data_in    = 8'h00;
    exp_bank   = '0;
    exp_cnt    = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_datos", datos_out, '0);
    check("rst_fv", BW'(frame_valid), BW'(0));
    check("rst_fe", BW'(frame_error), BW'(0));
    check("rst_cnt", BW'(frame_cnt), BW'(0));
    check("rst_state", BW'(dbg_state), BW'(0));
    @(negedge clk);
    reset = 1'b1;
    idle(4);
    check("hunt_state", BW'(dbg_state), BW'(0));

    // three back-to-back frames 0x01..0x0B
    first_sync();
    check("mark_state", BW'(dbg_state), BW'(1));
    for (int f = 0; f < 3; f++) begin
      good_frame(8'h01);
      commit_sync();
    end
    check("bb_byte0", BW'(datos_out[7:0]), BW'(8'h01));
    check("bb_byte10", BW'(datos_out[87:80]), BW'(8'h0B));
    check("bb_cnt", BW'(frame_cnt), BW'(3));

    // bad marker: error one cycle after marker, bank held, resync on next sync
    send_body(8'h5A, 8'h00, 0);
    check_bank("badmark");
    idle(11);
    first_sync();
    good_frame(8'h10);
    commit_sync();

    // early sync at data slot 6: error, no commit, that sync starts the next frame
    send_body(8'h00, 8'h70, 5);
    slot(1'b0, 8'h66, 1'b0, 1'b1);
    check_bank("early");
    good_frame(8'h20);
    commit_sync();

    // missing sync after slot 11
    send_body(8'h00, 8'h30, N_DATA);
    slot(1'b1, 8'h00, 1'b0, 1'b1);
    check_bank("nosync");
    idle(3);
    first_sync();
    good_frame(8'h40);
    commit_sync();

    // reset at slot 5 of a frame: outputs clear at once
    send_body(8'h00, 8'h90, 4);
    @(negedge clk);
    reset = 1'b0;
    #1;
    exp_bank = '0;
    exp_cnt  = 8'd0;
    exp_q.delete();
    check_bank("midrst");
    check("midrst_state", BW'(dbg_state), BW'(0));
    repeat (2) @(negedge clk);
    reset = 1'b1;
    idle(4);
    first_sync();
    good_frame(8'h50);
    commit_sync();
    check("post_rst_cnt", BW'(frame_cnt), BW'(1));

    // counter wrap: 255 more commits take frame_cnt from 1 through 255 to 0
    n_fv = 0;
    for (int i = 0; i < 255; i++) begin
      good_frame(8'(i));
      commit_sync();
    end
    check("wrap_pulses", BW'(n_fv), BW'(255));
    check("wrap_cnt", BW'(frame_cnt), BW'(0));
    good_frame(8'hE0);
    commit_sync();
    check("after_wrap_cnt", BW'(frame_cnt), BW'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
